// File: rtl/maxpool_ctrl.sv
// Sequencer for the 2x2 max-pool stage: scans a feature map two rows at a time and
// captures every odd-column pool result. Optional fused ReLU: MAXPOOL_CTRL_RELU_EN.
module maxpool_ctrl #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned IN_W      = 28,
    parameter int unsigned IN_H      = 28,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rd_addr1,
    output logic [ADDR_W-1:0]    rd_addr2,
    input  logic [BIT_WIDTH-1:0] rd_data1,
    input  logic [BIT_WIDTH-1:0] rd_data2,
    output logic                 pool_en,
    output logic [BIT_WIDTH-1:0] pool_in1,
    output logic [BIT_WIDTH-1:0] pool_in2,
    input  logic [BIT_WIDTH-1:0] pool_max,
    output logic                 out_valid,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [BIT_WIDTH-1:0] out_data
);

    localparam int unsigned CW   = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned RW   = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int unsigned NOUT = (IN_H / 2) * (IN_W / 2);

    localparam logic [CW-1:0]     C_LAST   = CW'(IN_W - 1);
    localparam logic [RW-1:0]     R_LAST   = RW'(IN_H - 2);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(NOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic [ADDR_W-1:0]     rd_addr1_d, rd_addr2_d;
    logic                  iss_valid_q, iss_valid_d;
    logic                  iss_odd_q, iss_odd_d;
    logic [ADDR_W-1:0]     iss_oaddr_q, iss_oaddr_d;
    logic                  s2_odd_q;
    logic [ADDR_W-1:0]     s2_oaddr_q;
    logic                  s3_valid_q, s3_odd_q;
    logic [ADDR_W-1:0]     s3_oaddr_q;
    logic                  busy_d, done_d, out_valid_d;
    logic [ADDR_W-1:0]     out_addr_d;
    logic [BIT_WIDTH-1:0]  out_data_d;
    logic                  capture;

    // Read data goes straight to the pool unit so it latches in the return cycle
    assign pool_in1 = rd_data1;
    assign pool_in2 = rd_data2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            c_q         <= '0;
            rd_addr1    <= '0;
            rd_addr2    <= ROW_STEP;
            iss_valid_q <= 1'b0;
            iss_odd_q   <= 1'b0;
            iss_oaddr_q <= '0;
            pool_en     <= 1'b0;
            s2_odd_q    <= 1'b0;
            s2_oaddr_q  <= '0;
            s3_valid_q  <= 1'b0;
            s3_odd_q    <= 1'b0;
            s3_oaddr_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            rd_addr1    <= rd_addr1_d;
            rd_addr2    <= rd_addr2_d;
            iss_valid_q <= iss_valid_d;
            iss_odd_q   <= iss_odd_d;
            iss_oaddr_q <= iss_oaddr_d;
            pool_en     <= iss_valid_q;
            s2_odd_q    <= iss_odd_q;
            s2_oaddr_q  <= iss_oaddr_q;
            s3_valid_q  <= pool_en;
            s3_odd_q    <= s2_odd_q;
            s3_oaddr_q  <= s2_oaddr_q;
            busy        <= busy_d;
            done        <= done_d;
            out_valid   <= out_valid_d;
            out_addr    <= out_addr_d;
            out_data    <= out_data_d;
        end
    end

    // pool_max covers columns c-1 and c here; only odd c closes a 2x2 window
    assign capture = s3_valid_q & s3_odd_q;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        rd_addr1_d  = rd_addr1;
        rd_addr2_d  = rd_addr2;
        iss_valid_d = 1'b0;
        iss_odd_d   = iss_odd_q;
        iss_oaddr_d = iss_oaddr_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        out_addr_d  = out_addr;
        out_data_d  = out_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    r_d         = '0;
                    c_d         = '0;
                    rd_addr1_d  = '0;
                    rd_addr2_d  = ROW_STEP;
                    iss_valid_d = 1'b1;
                    iss_odd_d   = 1'b0;
                    iss_oaddr_d = '0;
                end
            end
            RUN: begin
                if (r_q == R_LAST && c_q == C_LAST) begin
                    state_d = DRAIN;
                end else begin
                    iss_valid_d = 1'b1;
                    iss_odd_d   = ~c_q[0];
                    iss_oaddr_d = iss_oaddr_q + ADDR_W'(c_q[0]);
                    if (c_q == C_LAST) begin
                        // Row-pair wrap skips the lower row already read
                        c_d        = '0;
                        r_d        = r_q + RW'(2);
                        rd_addr1_d = rd_addr1 + ROW_STEP + ADDR_W'(1);
                    end else begin
                        c_d        = c_q + CW'(1);
                        rd_addr1_d = rd_addr1 + ADDR_W'(1);
                    end
                    rd_addr2_d = rd_addr1_d + ROW_STEP;
                end
            end
            DRAIN: begin
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            out_valid_d = 1'b1;
            out_addr_d  = s3_oaddr_q;
            done_d      = (s3_oaddr_q == OUT_LAST);
`ifdef MAXPOOL_CTRL_RELU_EN
            out_data_d  = pool_max[BIT_WIDTH-1] ? {BIT_WIDTH{1'b0}} : pool_max;
`else
            out_data_d  = pool_max;
`endif
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Scoreboard bench for maxpool_ctrl with a synchronous dual-read memory and a 2x2 pool model.
module tb_maxpool_ctrl;

    localparam int unsigned BW = 32;
    localparam int unsigned W  = 28;
    localparam int unsigned H  = 28;
    localparam int unsigned AW = 10;
    localparam int unsigned N  = (H / 2) * (W / 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, pool_en, out_valid;
    logic [AW-1:0] rd_addr1, rd_addr2, out_addr;
    logic [BW-1:0] rd_data1, rd_data2, pool_in1, pool_in2, pool_max, out_data;

    always #5 clk = ~clk;

    maxpool_ctrl #(.BIT_WIDTH(BW), .IN_W(W), .IN_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .pool_en(pool_en), .pool_in1(pool_in1), .pool_in2(pool_in2), .pool_max(pool_max),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
    );

    // Feature-map memory, one-cycle read latency
    logic signed [BW-1:0] mem [W*H];
    always @(posedge clk) begin
        rd_data1 <= mem[rd_addr1];
        rd_data2 <= mem[rd_addr2];
    end

    // Max-pool unit: column max registers plus combinational max of last two columns
    logic signed [BW-1:0] col_prev = '0, col_cur = '0;
    always @(posedge clk) begin
        if (pool_en) begin
            col_prev <= col_cur;
            col_cur  <= ($signed(pool_in1) > $signed(pool_in2)) ? pool_in1 : pool_in2;
        end
    end
    assign pool_max = (col_prev > col_cur) ? col_prev : col_cur;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        bit            last;
        int            cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0;
    int cyc = 0, base = 0;
    int done_cnt = 0, done_at = -1, out_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pops one expected entry
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                out_cnt++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got addr=%0d data=%0d expected no output", out_addr, out_data);
                end else begin
                    e = q.pop_front();
                    check("out_addr", longint'(out_addr), longint'(e.addr));
                    check("out_data", longint'(out_data), longint'(e.data));
                    check("out_cycle", longint'(cyc - base), longint'(e.cyc));
                    check("done_with_out", longint'(done), longint'(e.last));
                end
            end else if (done) begin
                total++;
                bad++;
                $display("FAIL done_alone: got done=1 expected done only with out_valid");
            end
            if (done) begin
                done_cnt++;
                done_at = cyc - base;
            end
        end
    end

    function automatic logic [BW-1:0] exp_val(input int p, input int qq);
        logic signed [BW-1:0] m;
        logic signed [BW-1:0] v;
        int r0;
        int c0;
        r0 = 2 * p;
        c0 = 2 * qq;
        m  = mem[r0 * W + c0];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = mem[(r0 + dr) * W + c0 + dc];
                if (v > m) m = v;
            end
`ifdef MAXPOOL_CTRL_RELU_EN
        if (m < 0) m = '0;
`endif
        return m;
    endfunction

    task automatic fill(input int mode);
        for (int a = 0; a < W * H; a++) begin
            if (mode == 0)      mem[a] = BW'(a);
            else if (mode == 1) mem[a] = BW'(W * H - 1 - a);
            else                mem[a] = -32'sd5;
        end
    endtask

    task automatic push_map();
        exp_t x;
        for (int i = 0; i < int'(N); i++) begin
            x.addr = AW'(i);
            x.data = exp_val(i / (W / 2), i % (W / 2));
            x.last = (i == int'(N) - 1);
            x.cyc  = 5 + 2 * i;
            q.push_back(x);
        end
    endtask

    // Called at a falling edge; that cycle becomes cycle 0 of the run
    task automatic start_map();
        base  = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - base < n) @(negedge clk);
    endtask

    task automatic end_checks(input string tag, input int oc0, input int dc0);
        check({tag, "_busy_low"}, longint'(busy), 0);
        check({tag, "_pool_en_low"}, longint'(pool_en), 0);
        check({tag, "_out_count"}, longint'(out_cnt - oc0), longint'(N));
        check({tag, "_done_count"}, longint'(done_cnt - dc0), 1);
        check({tag, "_done_cycle"}, longint'(done_at), 395);
        check({tag, "_queue_empty"}, longint'(q.size()), 0);
    endtask

    task automatic full_run(input string tag, input int mode);
        int oc0, dc0;
        fill(mode);
        push_map();
        oc0 = out_cnt;
        dc0 = done_cnt;
        start_map();
        check({tag, "_busy_c1"}, longint'(busy), 1);
        wait_rel(396);
        end_checks(tag, oc0, dc0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int oc0, dc0, b0;
        rst   = 1'b0;
        start = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_rd_addr1", longint'(rd_addr1), 0);
        check("rst_rd_addr2", longint'(rd_addr2), longint'(W));
        check("rst_out_data", longint'(out_data), 0);
        rst = 1'b1;
        @(negedge clk);

        full_run("asc", 0);
        full_run("desc", 1);
        full_run("neg5", 2);

        // Start pulses during a run are ignored
        fill(0);
        push_map();
        oc0 = out_cnt;
        dc0 = done_cnt;
        start_map();
        wait_rel(50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rel(395);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        end_checks("restart", oc0, dc0);
        repeat (4) @(negedge clk);
        check("restart_still_idle", longint'(busy), 0);

        // Asynchronous reset mid-map, then a fresh run
        push_map();
        oc0 = out_cnt;
        dc0 = done_cnt;
        start_map();
        wait_rel(100);
        rst = 1'b0;
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_pool_en", longint'(pool_en), 0);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_out_addr", longint'(out_addr), 0);
        check("abort_out_data", longint'(out_data), 0);
        check("abort_rd_addr1", longint'(rd_addr1), 0);
        q.delete();
        oc0 = out_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_rel(110);
        check("abort_no_out", longint'(out_cnt - oc0), 0);
        check("abort_no_done", longint'(done_cnt - dc0), 0);
        push_map();
        oc0 = out_cnt;
        dc0 = done_cnt;
        start_map();
        wait_rel(396);
        end_checks("after_abort", oc0, dc0);

        // Back-to-back maps: second start lands in the cycle after done
        push_map();
        oc0 = out_cnt;
        dc0 = done_cnt;
        start_map();
        b0 = base;
        wait_rel(396);
        end_checks("b2b_first", oc0, dc0);
        push_map();
        oc0 = out_cnt;
        dc0 = done_cnt;
        start_map();
        wait_rel(396);
        end_checks("b2b_second", oc0, dc0);
        check("b2b_done_abs", longint'(base - b0 + done_at), 791);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
